// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared mode encodings and control-FSM state type for chan_mux_seq.
package chan_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_e;

endpackage

// File: rtl/chan_mux_seq_if.sv
// chan_mux_seq_if: channel inputs, select controls and valid/ready output bundle.
// Optional sel_err flag is present only when CHAN_MUX_SEQ_SEL_CHECK_EN is defined.
interface chan_mux_seq_if #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned W    = 1,
   parameter int unsigned SELW = $clog2(NCH)
);
   logic [NCH*W-1:0] ch_data;
   logic             mode;
   logic [SELW-1:0]  sel;
   logic             sel_load;
   logic [W-1:0]     out_data;
   logic [SELW-1:0]  out_ch;
   logic             out_valid;
   logic             out_ready;
`ifdef CHAN_MUX_SEQ_SEL_CHECK_EN
   logic             sel_err;

   modport master (
      output ch_data, mode, sel, sel_load, out_ready,
      input  out_data, out_ch, out_valid, sel_err
   );
   modport slave (
      input  ch_data, mode, sel, sel_load, out_ready,
      output out_data, out_ch, out_valid, sel_err
   );
`else
   modport master (
      output ch_data, mode, sel, sel_load, out_ready,
      input  out_data, out_ch, out_valid
   );
   modport slave (
      input  ch_data, mode, sel, sel_load, out_ready,
      output out_data, out_ch, out_valid
   );
`endif
endinterface

// File: rtl/chan_mux_out_reg.sv
// chan_mux_out_reg: single-entry valid/ready output register. Loads whenever it is
// empty or its content is being accepted; holds while the consumer stalls.
module chan_mux_out_reg #(
   parameter int unsigned DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data_i,
   output logic [DW-1:0] out_data_o,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic          cap_o
);

   logic [DW-1:0] data_q;
   logic          valid_q;

   assign cap_o       = !valid_q || out_ready_i;
   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;

   // Capture on cap; once valid the stage never empties, it only stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (cap_o) begin
         data_q  <= in_data_i;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq: NCH x W-bit channel selector with manual select or round-robin scan
// (DWELL accepted samples per channel) feeding a registered valid/ready output.
// Define CHAN_MUX_SEQ_SEL_CHECK_EN to add the sticky out-of-range select flag sel_err.
module chan_mux_seq
   import chan_mux_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned W     = 1,
   parameter int unsigned DWELL = 4
) (
   input logic           clk,
   input logic           rst,
   chan_mux_seq_if.slave bus
);

   localparam int unsigned SELW = $clog2(NCH);
   localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SELW:0]   NCH_V      = (SELW + 1)'(NCH);
   localparam logic [SELW-1:0] CH_LAST    = SELW'(NCH - 1);
   localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);

   state_e          state_q;
   logic [SELW-1:0] cur_ch_q;
   logic [CNTW-1:0] dwell_q;
   logic [W-1:0]    sel_data;
   logic            sel_ok;
   logic            load_ok;
   logic            cap;
   logic [W+SELW-1:0] out_word;

   // Out-of-range selects only occur for non-power-of-two NCH; they are dropped.
   assign sel_ok  = {1'b0, bus.sel} < NCH_V;
   assign load_ok = bus.sel_load && sel_ok;

   // Channel mux driven by the current-channel register.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (cur_ch_q == SELW'(k)) sel_data = bus.ch_data[k*W +: W];
      end
   end

   // Control FSM: advances only on a capture so a stall freezes channel and dwell.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_MANUAL;
         cur_ch_q <= '0;
         dwell_q  <= '0;
      end else if (cap) begin
         unique case (state_q)
            ST_MANUAL: begin
               dwell_q <= '0;
               if (bus.mode == MODE_SCAN) state_q <= ST_SCAN;
               if (load_ok) cur_ch_q <= bus.sel;
            end
            ST_SCAN: begin
               if (bus.mode == MODE_MANUAL) begin
                  state_q <= ST_MANUAL;
                  dwell_q <= '0;
                  if (load_ok) cur_ch_q <= bus.sel;
               end else if (load_ok) begin
                  // An explicit load beats a same-cycle scan advance.
                  cur_ch_q <= bus.sel;
                  dwell_q  <= '0;
               end else if (dwell_q == DWELL_LAST) begin
                  dwell_q  <= '0;
                  cur_ch_q <= (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   chan_mux_out_reg #(
      .DW (W + SELW)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   ({sel_data, cur_ch_q}),
      .out_data_o  (out_word),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .cap_o       (cap)
   );

   assign bus.out_data = out_word[W+SELW-1:SELW];
   assign bus.out_ch   = out_word[SELW-1:0];

`ifdef CHAN_MUX_SEQ_SEL_CHECK_EN
   logic sel_err_q;

   // Sticky record of any out-of-range select load; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else if (bus.sel_load && !sel_ok) begin
         sel_err_q <= 1'b1;
      end
   end

   assign bus.sel_err = sel_err_q;
`endif

endmodule
